seq_add_sub: RTL and testbench
==============================

Name: seq_add_sub

Overview:
Multi-cycle, parametrised two's-complement adder/subtractor for operands wider than a single-cycle ripple chain should span. Processes SLICE bits per clock, least-significant slice first, and registers the inter-slice carry. Operands enter and results leave through valid/ready handshakes. Sits in the datapath library as the wide-operand successor to the 4-bit ripple add/sub cell, with status flags added.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
SLICE, 4, bits computed per clock; SLICE = WIDTH gives a 1-cycle compute.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
sub  input  1  0 = a + b, 1 = a - b; sampled with operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum or difference, modulo 2^WIDTH
carry_out  output  1  carry out of MSB; on subtract, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Reset (async, active-high), applied immediately and independent of clk:
  - state = IDLE; in_ready = 1.
  - out_valid, result, carry_out, overflow, zero = 0.
  - Internal operand, carry and slice-index registers = 0.
- Derived constant: N = WIDTH/SLICE. Elaboration must fail if WIDTH % SLICE != 0 or SLICE < 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On a clock edge with in_valid = 1:
    - capture a, b, sub; capture b as b XOR {WIDTH{sub}}.
    - carry register := sub; idx := 0.
    - go to RUN.
  - a, b and sub are ignored at all other times.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge:
    - adds slice idx of A, slice idx of the inverted-or-not B, and the carry register.
    - writes the SLICE-bit sum into result[idx*SLICE +: SLICE].
    - carry register := slice carry out; idx := idx+1.
  - On the edge that processes idx = N-1:
    - carry_out := final carry.
    - overflow := carry into bit WIDTH-1 XOR final carry (computed bit-level within the last slice).
    - zero := (complete result == 0).
    - go to DONE.
- Latency: out_valid rises exactly N cycles after the accepting edge.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result and all flags are held stable while out_ready = 0 (no limit on stall length).
  - On an edge with out_ready = 1: go to IDLE, out_valid := 0.
  - result and flags keep their values until the next operation overwrites them.
- Throughput: one operation per N+2 cycles minimum (accept, N compute, handshake). No overlap of operations.
- Intermediate result bits are visible during RUN. Consumers must qualify result with out_valid.
- Reset mid-RUN or mid-DONE aborts the operation. No result is produced, and the block returns to IDLE with all outputs reset.
- in_valid held high in DONE is not accepted until the cycle after the output handshake completes (state is IDLE).

Test Plan:
- WIDTH=16, SLICE=4: sub=0, a=0x7FFF, b=0x0001 -> out_valid exactly 4 cycles after accept; result=0x8000, carry_out=0, overflow=1, zero=0.
- sub=0, a=0xFFFF, b=0x0001 -> result=0x0000, carry_out=1, overflow=0, zero=1.
- sub=1, a=0x0003, b=0x0005 -> result=0xFFFE, carry_out=0 (borrow), overflow=0; then sub=1, a=0x8000, b=0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid held at 1 and a/b changing -> result and flags stable, in_ready=0. Release out_ready -> IDLE, next operand accepted the following edge.
- Reset asserted asynchronously mid-clock during RUN (idx=2) -> all outputs 0 and in_ready=1 immediately. A following operation (sub=0, a=0x1234, b=0x4321) gives result=0x5555.
- Re-run with SLICE=16 (N=1) and SLICE=1 (N=16), random operands vs. reference model -> latency equals N, and all outputs match (a±b) mod 2^16 with correct flags.

Source files
------------

// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: SLICE bits per clock, LSB slice
// first, with a registered inter-slice carry and valid/ready handshakes on both sides.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N    = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  generate
    if ((SLICE < 1) || ((WIDTH % ((SLICE > 0) ? SLICE : 1)) != 0)) begin : g_param_check
      $error("seq_add_sub: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [SLICE-1:0] a_slices [N];
  logic [SLICE-1:0] b_slices [N];
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] sum_slice;
  logic             slice_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] result_next;

  // Slice views of the operands, and the result with the active slice replaced.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
      assign result_next[gi*SLICE +: SLICE] =
        (idx_reg == IDXW'(gi)) ? sum_slice : result_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_slice = a_slices[idx_reg];
  assign b_slice = b_slices[idx_reg];

  // Bit-level ripple inside the slice so the carry into the top bit is available
  // for the overflow flag on the last slice.
  always_comb begin : slice_add
    logic c;
    c         = carry_reg;
    msb_cin   = carry_reg;
    sum_slice = '0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) begin
        msb_cin = c;
      end
      sum_slice[i] = a_slice[i] ^ b_slice[i] ^ c;
      c = (a_slice[i] & b_slice[i]) | (c & (a_slice[i] ^ b_slice[i]));
    end
    slice_cout = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b ^ {WIDTH{sub}};
            carry_reg    <= sub;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= slice_cout;
          idx_reg    <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            idx_reg       <= '0;
            carry_out_reg <= slice_cout;
            overflow_reg  <= msb_cin ^ slice_cout;
            zero_reg      <= (result_next == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: three instances (SLICE = 4, 16, 1 at WIDTH = 16) checked
// against an integer-arithmetic reference model.
module tb_seq_add_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid_s  [3];
  logic         sub_s       [3];
  logic         out_ready_s [3];
  logic [W-1:0] a_s         [3];
  logic [W-1:0] b_s         [3];
  logic         in_ready_s  [3];
  logic         out_valid_s [3];
  logic [W-1:0] result_s    [3];
  logic         carry_s     [3];
  logic         ovf_s       [3];
  logic         zero_s      [3];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(W), .SLICE(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .sub(sub_s[0]), .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .result(result_s[0]), .carry_out(carry_s[0]),
    .overflow(ovf_s[0]), .zero(zero_s[0])
  );

  seq_add_sub #(.WIDTH(W), .SLICE(16)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .sub(sub_s[1]), .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .result(result_s[1]), .carry_out(carry_s[1]),
    .overflow(ovf_s[1]), .zero(zero_s[1])
  );

  seq_add_sub #(.WIDTH(W), .SLICE(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .sub(sub_s[2]), .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .result(result_s[2]), .carry_out(carry_s[2]),
    .overflow(ovf_s[2]), .zero(zero_s[2])
  );

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [W+2:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, sr;
    logic [W-1:0] r;
    logic co, ov, z;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = x - y;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = x + y;
      co = ((ux + uy) > 65535);
      sr = sx + sy;
    end
    ov = (sr > 32767) || (sr < -32768);
    z  = (r == '0);
    return {r, co, ov, z};
  endfunction

  // Stimulus helper: issue one op on instance k, wait for out_valid, capture, handshake.
  task automatic do_op(input int k, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic [W+2:0] obs);
    sub_s[k]      = s;
    a_s[k]        = x;
    b_s[k]        = y;
    in_valid_s[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
    lat = 0;
    while (!out_valid_s[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {result_s[k], carry_s[k], ovf_s[k], zero_s[k]};
    $display("op dut%0d sub=%0b a=%h b=%h -> result=%h c=%0b v=%0b z=%0b lat=%0d",
             k, s, x, y, obs[W+2:3], obs[2], obs[1], obs[0], lat);
    out_ready_s[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({in_ready_s[k], out_valid_s[k], result_s[k], carry_s[k], ovf_s[k], zero_s[k]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got rdy=%b vld=%b res=%h c=%b v=%b z=%b want rdy=1 vld=0 all else 0",
                 k, in_ready_s[k], out_valid_s[k], result_s[k], carry_s[k], ovf_s[k], zero_s[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rdy=%b vld=%b want rdy=1 vld=0", in_ready_s[0], out_valid_s[0]);
    end
  endtask

  task automatic test_directed();
    logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ta [4] = '{16'h7FFF, 16'hFFFF, 16'h0003, 16'h8000};
    logic [W-1:0] tb [4] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001};
    logic [W+2:0] te [4] = '{{16'h8000, 3'b010}, {16'h0000, 3'b101},
                             {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}};
    int lat;
    logic [W+2:0] obs;
    for (int i = 0; i < 4; i++) begin
      do_op(0, ts[i], ta[i], tb[i], lat, obs);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      vectors++;
      if (obs !== te[i]) begin
        miscompares++;
        $display("FAIL directed%0d_result: got res=%h cvz=%b want res=%h cvz=%b",
                 i, obs[W+2:3], obs[2:0], te[i][W+2:3], te[i][2:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] exp_first, exp_next, obs;
    logic [W-1:0] nx, ny;
    logic         ns;
    int lat;
    exp_first = model(1'b0, 16'h1111, 16'h2222);
    sub_s[0] = 1'b0; a_s[0] = 16'h1111; b_s[0] = 16'h2222; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid_s[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      a_s[0]   = W'($urandom);
      b_s[0]   = W'($urandom);
      sub_s[0] = 1'($urandom);
      @(posedge clk); #1;
      obs = {result_s[0], carry_s[0], ovf_s[0], zero_s[0]};
      vectors++;
      if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0 || obs !== exp_first) begin
        miscompares++;
        $display("FAIL stall_hold cycle%0d: got vld=%b rdy=%b res=%h cvz=%b want vld=1 rdy=0 res=%h cvz=%b",
                 c, out_valid_s[0], in_ready_s[0], obs[W+2:3], obs[2:0], exp_first[W+2:3], exp_first[2:0]);
      end
    end
    $display("op dut0 stalled result=%h held for 5 cycles", obs[W+2:3]);
    nx = W'($urandom); ny = W'($urandom); ns = 1'($urandom);
    a_s[0] = nx; b_s[0] = ny; sub_s[0] = ns;
    exp_next = model(ns, nx, ny);
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
    vectors++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL release_to_idle: got vld=%b rdy=%b want vld=0 rdy=1", out_valid_s[0], in_ready_s[0]);
    end
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    vectors++;
    if (in_ready_s[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_after_release: got rdy=%b want 0", in_ready_s[0]);
    end
    lat = 0;
    while (!out_valid_s[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {result_s[0], carry_s[0], ovf_s[0], zero_s[0]};
    $display("op dut0 sub=%0b a=%h b=%h -> result=%h lat=%0d (after stall)", ns, nx, ny, obs[W+2:3], lat);
    vectors++;
    if (lat !== 4 || obs !== exp_next) begin
      miscompares++;
      $display("FAIL post_stall_op: got lat=%0d res=%h cvz=%b want lat=4 res=%h cvz=%b",
               lat, obs[W+2:3], obs[2:0], exp_next[W+2:3], exp_next[2:0]);
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat;
    logic [W+2:0] obs;
    sub_s[0] = 1'b0; a_s[0] = 16'h0F0F; b_s[0] = 16'h0101; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready_s[0], out_valid_s[0], result_s[0], carry_s[0], ovf_s[0], zero_s[0]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL async_reset_midrun: got rdy=%b vld=%b res=%h c=%b v=%b z=%b want rdy=1 vld=0 all else 0",
               in_ready_s[0], out_valid_s[0], result_s[0], carry_s[0], ovf_s[0], zero_s[0]);
    end
    $display("op dut0 reset during RUN, result=%h", result_s[0]);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(0, 1'b0, 16'h1234, 16'h4321, lat, obs);
    vectors++;
    if (lat !== 4 || obs !== {16'h5555, 3'b000}) begin
      miscompares++;
      $display("FAIL op_after_reset: got lat=%0d res=%h cvz=%b want lat=4 res=5555 cvz=000",
               lat, obs[W+2:3], obs[2:0]);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W+2:0] obs, exp;
    logic [W-1:0] x, y;
    logic s;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 15; i++) begin
        x = W'($urandom);
        y = W'($urandom);
        s = 1'($urandom);
        if ($urandom_range(0, 3) == 0) x = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
        if ($urandom_range(0, 3) == 0) y = (i % 3 == 0) ? x : 16'h7FFF;
        exp = model(s, x, y);
        do_op(k, s, x, y, lat, obs);
        vectors++;
        if (lat !== n_of(k) || obs !== exp) begin
          miscompares++;
          $display("FAIL random dut%0d op%0d: got lat=%0d res=%h cvz=%b want lat=%0d res=%h cvz=%b",
                   k, i, lat, obs[W+2:3], obs[2:0], n_of(k), exp[W+2:3], exp[2:0]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k]  = 1'b0;
      sub_s[k]       = 1'b0;
      out_ready_s[k] = 1'b0;
      a_s[k]         = '0;
      b_s[k]         = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
